// File: rtl/gesture_area_locator.sv
// Per-frame skin-pixel count and bounding box of a masked RGB stream, published at vsync rise.
// Optional centroid outputs enabled by defining GESTURE_CENTROID_EN.
module gesture_area_locator #(
  parameter int MIN_PIXELS = 256,
  parameter int COORD_W    = 11,
  parameter int CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gesture_vsync,
  input  logic               gesture_clken,
  input  logic               gesture_valid,
  input  logic [23:0]        gesture_data,
  output logic               box_valid,
  output logic               area_found,
  output logic [COORD_W-1:0] box_left,
  output logic [COORD_W-1:0] box_right,
  output logic [COORD_W-1:0] box_top,
  output logic [COORD_W-1:0] box_bottom,
  output logic [CNT_W-1:0]   pixel_cnt
`ifdef GESTURE_CENTROID_EN
  ,
  output logic [COORD_W-1:0] centroid_x,
  output logic [COORD_W-1:0] centroid_y
`endif
);

  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [CNT_W-1:0]   N_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   N_MIN  = CNT_W'(MIN_PIXELS);

  logic               r_vsync_d, r_valid_d, r_frame_seen;
  logic [COORD_W-1:0] r_x, r_y;
  logic [CNT_W-1:0]   r_count;
  logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;

  logic w_pix, w_skin, w_line_end, w_fr, w_found;

  assign w_pix      = gesture_clken & gesture_valid & ~gesture_vsync;
  assign w_skin     = w_pix & (gesture_data != 24'd0);
  assign w_line_end = r_valid_d & ~gesture_valid;
  assign w_fr       = gesture_vsync & ~r_vsync_d;
  assign w_found    = (r_count >= N_MIN);

`ifdef GESTURE_CENTROID_EN
  logic [COORD_W:0] w_sum_x, w_sum_y;
  assign w_sum_x = {1'b0, r_min_x} + {1'b0, r_max_x};
  assign w_sum_y = {1'b0, r_min_y} + {1'b0, r_max_y};
`endif

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d    <= 1'b0;
      r_valid_d    <= 1'b0;
      r_frame_seen <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_count      <= '0;
      r_min_x      <= '1;
      r_max_x      <= '0;
      r_min_y      <= '1;
      r_max_y      <= '0;
      box_valid    <= 1'b0;
      area_found   <= 1'b0;
      box_left     <= '0;
      box_right    <= '0;
      box_top      <= '0;
      box_bottom   <= '0;
      pixel_cnt    <= '0;
`ifdef GESTURE_CENTROID_EN
      centroid_x   <= '0;
      centroid_y   <= '0;
`endif
    end else begin
      r_vsync_d <= gesture_vsync;
      r_valid_d <= gesture_valid;
      box_valid <= 1'b0;

      if (w_fr) begin
        // Publish the frame just ended, then restart accumulation; the clear wins over a line end.
        if (r_frame_seen) begin
          box_valid  <= 1'b1;
          pixel_cnt  <= r_count;
          area_found <= w_found;
          box_left   <= w_found ? r_min_x : '0;
          box_right  <= w_found ? r_max_x : '0;
          box_top    <= w_found ? r_min_y : '0;
          box_bottom <= w_found ? r_max_y : '0;
`ifdef GESTURE_CENTROID_EN
          centroid_x <= w_found ? w_sum_x[COORD_W:1] : '0;
          centroid_y <= w_found ? w_sum_y[COORD_W:1] : '0;
`endif
        end
        r_frame_seen <= 1'b1;
        r_x          <= '0;
        r_y          <= '0;
        r_count      <= '0;
        r_min_x      <= '1;
        r_max_x      <= '0;
        r_min_y      <= '1;
        r_max_y      <= '0;
      end else begin
        if (w_skin) begin
          if (r_count != '1) r_count <= r_count + N_ONE;
          if (r_x < r_min_x) r_min_x <= r_x;
          if (r_x > r_max_x) r_max_x <= r_x;
          if (r_y < r_min_y) r_min_y <= r_y;
          if (r_y > r_max_y) r_max_y <= r_y;
        end
        if (w_line_end) begin
          r_x <= '0;
          if (r_y != '1) r_y <= r_y + C_ONE;
        end else if (w_pix && r_x != '1) begin
          r_x <= r_x + C_ONE;
        end
      end
    end
  end

endmodule
